// File: rtl/scan_decoder.sv
// Registered N-way active-low decoder with 138-style enables
// and a prescaled scan sequencer that skips masked channels.
module scan_decoder #(
    parameter int SEL_W = 3,
    parameter int DIV_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 e1_n,
    input  logic                 e2_n,
    input  logic                 e3,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     a,
    input  logic [DIV_W-1:0]     div,
    input  logic [(1<<SEL_W)-1:0] mask,
    output logic [(1<<SEL_W)-1:0] y_n,
    output logic [SEL_W-1:0]     sel,
    output logic                 tick
);

    localparam int N = 1 << SEL_W;

    logic             en;
    logic             step;
    logic             found;
    logic [SEL_W-1:0] nxt;
    logic [SEL_W-1:0] idx;
    logic [DIV_W-1:0] cnt;

    function automatic logic [N-1:0] dec_n(input logic [SEL_W-1:0] s);
        return ~(N'(1) << s);
    endfunction

    assign en   = e3 & ~e1_n & ~e2_n;
    assign step = (cnt >= div);

    // Search sel+1 .. sel+N; the last candidate is sel itself.
    always_comb begin
        nxt   = sel;
        found = 1'b0;
        idx   = sel;
        for (int k = 1; k <= N; k++) begin
            idx = sel + SEL_W'(k);
            if (!found && mask[idx]) begin
                nxt   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_n  <= '1;
            sel  <= '0;
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            y_n  <= '1;
            tick <= 1'b0;
        end else if (!mode) begin
            sel  <= a;
            y_n  <= dec_n(a);
            cnt  <= '0;
            tick <= 1'b0;
        end else if (step) begin
            cnt <= '0;
            if (found) begin
                sel  <= nxt;
                y_n  <= dec_n(nxt);
                tick <= 1'b1;
            end else begin
                y_n  <= '1;
                tick <= 1'b0;
            end
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
            y_n  <= mask[sel] ? dec_n(sel) : '1;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder (SEL_W=3, DIV_W=16).
module tb_scan_decoder;

    logic        clk;
    logic        rst;
    logic        e1_n;
    logic        e2_n;
    logic        e3;
    logic        mode;
    logic [2:0]  a;
    logic [15:0] div;
    logic [7:0]  mask;
    logic [7:0]  y_n;
    logic [2:0]  sel;
    logic        tick;

    int checks = 0;
    int errors = 0;

    scan_decoder #(.SEL_W(3), .DIV_W(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .e1_n (e1_n),
        .e2_n (e2_n),
        .e3   (e3),
        .mode (mode),
        .a    (a),
        .div  (div),
        .mask (mask),
        .y_n  (y_n),
        .sel  (sel),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] ey,
                              input logic [2:0] es, input logic et);
        checks++;
        if (y_n !== ey || sel !== es || tick !== et) begin
            errors++;
            $display("FAIL %s: y_n=%h sel=%0d tick=%b, required y_n=%h sel=%0d tick=%b",
                     name, y_n, sel, tick, ey, es, et);
        end
    endtask

    function automatic logic [7:0] dn(input logic [2:0] s);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << s);
    endfunction

    task automatic load_direct(input logic [2:0] addr);
        mode = 1'b0;
        a    = addr;
        cyc();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        expect_out("reset_initial", 8'hFF, 3'd0, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        load_direct(3'd6);
        expect_out("pre_reset_sel6", 8'hBF, 3'd6, 1'b0);
        mode = 1'b1;
        div  = 16'd2;
        mask = 8'hFF;
        cyc();
        rst = 1'b1;
        #1;
        expect_out("reset_async_mid_scan", 8'hFF, 3'd0, 1'b0);
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_direct();
        load_direct(3'd5);
        expect_out("direct_a5", 8'hDF, 3'd5, 1'b0);
        e3 = 1'b0;
        cyc();
        expect_out("direct_e3_low", 8'hFF, 3'd5, 1'b0);
        e2_n = 1'b1;
        e3   = 1'b1;
        cyc();
        expect_out("direct_e2n_high", 8'hFF, 3'd5, 1'b0);
        e2_n = 1'b0;
        load_direct(3'd0);
        expect_out("direct_a0", 8'hFE, 3'd0, 1'b0);
        mask = 8'h00;
        load_direct(3'd7);
        expect_out("direct_a7_mask_ignored", 8'h7F, 3'd7, 1'b0);
    endtask

    task automatic test_scan_div2();
        logic [2:0] es;
        load_direct(3'd0);
        mode = 1'b1;
        div  = 16'd2;
        mask = 8'hFF;
        for (int s = 1; s <= 8; s++) begin
            for (int e = 1; e <= 3; e++) begin
                cyc();
                es = (e == 3) ? 3'(s) : 3'(s - 1);
                expect_out($sformatf("scan_div2_s%0d_e%0d", s, e),
                           dn(es), es, (e == 3));
            end
        end
    endtask

    task automatic test_scan_mask();
        logic [2:0] seq [4];
        seq = '{3'd5, 3'd7, 3'd2, 3'd5};
        load_direct(3'd2);
        mode = 1'b1;
        div  = 16'd0;
        mask = 8'b1010_0100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            expect_out($sformatf("scan_mask_seq%0d", i), dn(seq[i]), seq[i], 1'b1);
        end
        mask = 8'b0000_0100;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_out($sformatf("scan_single_bit%0d", i), 8'hFB, 3'd2, 1'b1);
        end
    endtask

    task automatic test_mask_zero_div();
        mask = 8'h00;
        for (int i = 0; i < 2; i++) begin
            cyc();
            expect_out($sformatf("scan_mask_zero%0d", i), 8'hFF, 3'd2, 1'b0);
        end
        mask = 8'hFF;
        load_direct(3'd0);
        mode = 1'b1;
        div  = 16'd9;
        for (int i = 0; i < 5; i++) cyc();
        expect_out("div9_cnt5_no_step", 8'hFE, 3'd0, 1'b0);
        div = 16'd1;
        cyc();
        expect_out("div_lowered_steps", 8'hFD, 3'd1, 1'b1);
    endtask

    task automatic test_enable_freeze();
        load_direct(3'd3);
        mode = 1'b1;
        div  = 16'd3;
        mask = 8'hFF;
        cyc();
        cyc();
        expect_out("freeze_pre_cnt2", 8'hF7, 3'd3, 1'b0);
        e1_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            expect_out($sformatf("freeze_e1n_high%0d", i), 8'hFF, 3'd3, 1'b0);
        end
        e1_n = 1'b0;
        cyc();
        expect_out("resume_cnt3", 8'hF7, 3'd3, 1'b0);
        cyc();
        expect_out("resume_step", 8'hEF, 3'd4, 1'b1);
    endtask

    task automatic test_back_to_back();
        mode = 1'b0;
        a    = 3'd6;
        cyc();
        expect_out("scan_to_direct", 8'hBF, 3'd6, 1'b0);
        mode = 1'b1;
        div  = 16'd0;
        mask = 8'h01;
        cyc();
        expect_out("direct_to_scan_step", 8'hFE, 3'd0, 1'b1);
        div  = 16'd5;
        mask = 8'hFF;
        cyc();
        mask = 8'hFE;
        cyc();
        expect_out("mask_blanks_current", 8'hFF, 3'd0, 1'b0);
    endtask

    initial begin
        rst  = 1'b0;
        e1_n = 1'b0;
        e2_n = 1'b0;
        e3   = 1'b1;
        mode = 1'b0;
        a    = 3'd0;
        div  = 16'd0;
        mask = 8'hFF;
        test_reset();
        test_direct();
        test_scan_div2();
        test_scan_mask();
        test_mask_zero_div();
        test_enable_freeze();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered N-way decoder with active-low one-hot outputs and 138-style triple enable (e1_n, e2_n, e3).
- Adds a scan mode: an internal prescaler steps through the channels automatically, skipping masked channels.
- Drives digit/row selects for multiplexed displays and LED matrices in lab top-levels.
- Replaces hand-instantiated combinational decoders plus separate scan counters.

Parameters:
- SEL_W, 3, select width; channel count N = 2^SEL_W (derived localparam).
- DIV_W, 16, prescaler width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- e1_n  in  1  enable, active-low.
- e2_n  in  1  enable, active-low.
- e3  in  1  enable, active-high.
- mode  in  1  0 = direct (channel from a), 1 = scan (channel from internal sequencer).
- a  in  SEL_W  direct-mode channel address.
- div  in  DIV_W  scan step period minus 1, in clk cycles.
- mask  in  N  scan channel include mask; 1 = channel participates.
- y_n  out  N  registered decoded output, active-low, at most one bit low.
- sel  out  SEL_W  registered current channel index.
- tick  out  1  registered one-cycle pulse, high the cycle after sel advanced in scan mode.

Behaviour:
- Reset (async, takes effect immediately, independent of clk): y_n = all ones, sel = 0, prescaler cnt = 0, tick = 0.
- en = e3 & ~e1_n & ~e2_n.
- en = 0:
  - y_n <= all ones on the next edge.
  - sel and cnt hold; tick <= 0.
  - When en returns, operation resumes from the held state.
- Direct mode (mode = 0, en = 1):
  - Each edge: sel <= a; y_n <= ~(1 << a); cnt <= 0; tick <= 0.
  - mask is ignored.
  - Latency: a to y_n/sel is 1 cycle.
- Scan mode (mode = 1, en = 1), prescaler:
  - If cnt >= div: cnt <= 0 and a step occurs.
  - Otherwise: cnt <= cnt + 1.
  - div = 0 gives a step every cycle.
  - If div is lowered below the current cnt, the step occurs on the next edge (>= compare, no wrap through 2^DIV_W).
- Step:
  - nxt = first index j in sel+1, sel+2, ... (mod N, wrapping N-1 to 0) with mask[j] = 1.
  - Search includes sel itself last, so a single-bit mask keeps sel fixed.
  - sel <= nxt; y_n <= ~(1 << nxt); tick <= 1.
  - tick is still pulsed when nxt == sel and mask[sel] = 1.
- Step with mask = 0: no qualifying channel; sel holds, y_n <= all ones, tick <= 0.
- Scan mode, no step this cycle:
  - sel holds; tick <= 0.
  - y_n <= ~(1 << sel) if mask[sel] = 1, else all ones, so a mask change on the current channel blanks it on the next edge.
- Mode change:
  - Direct to scan: sel starts from the last direct address and cnt starts at 0. First step after div+1 cycles.
  - Scan to direct: the next edge loads a and clears cnt.
- Simultaneous events:
  - rst dominates all inputs.
  - en = 0 dominates mode and step.
- Invariant: y_n never has more than one zero bit.

Test Plan (SEL_W = 3, DIV_W = 16):
- Reset: assert rst mid-scan with sel = 6 → y_n = 8'hFF, sel = 0, tick = 0 immediately, before the next clk edge.
- Direct mode with en = 1, a = 5 → next edge y_n = 8'b1101_1111, sel = 5. Then drive e3 = 0 → next edge y_n = 8'hFF, sel stays 5. Then e2_n = 1 with e3 = 1 → still 8'hFF.
- Scan, div = 2, mask = 8'hFF, from sel = 0:
  - sel goes 1, 2, …, 7, 0 on every third edge.
  - tick high exactly 1 cycle in 3.
  - At sel = 7, y_n = 8'b0111_1111; wraps to 8'b1111_1110.
- Scan, div = 0, mask = 8'b1010_0100, start sel = 2 → sel sequence 5, 7, 2, 5 on consecutive edges with tick high every cycle. Then set mask = 8'b0000_0100 → sel stays 2 and tick keeps pulsing.
- Scan, mask = 8'h00 → y_n = 8'hFF, sel holds, tick = 0. Then div = 9 with cnt = 5, change div to 1 → a step occurs on the next edge (cnt 5 >= 1).
- Scan, div = 3: drop e1_n to 1 at cnt = 2 for 10 cycles → y_n = 8'hFF, sel and cnt frozen. Restore e1_n = 0 → the next step comes after exactly 2 more edges (cnt 2→3, then step).
